// File: rtl/cnt_pkg.sv
// Shared types, constants and count arithmetic for the presettable up/down counter family.
package cnt_pkg;

  localparam int unsigned CALC_W = 64;

  localparam logic UP      = 1'b1;
  localparam logic DN      = 1'b0;
  localparam logic WRAP    = 1'b0;
  localparam logic ONESHOT = 1'b1;

  typedef logic [CALC_W-1:0] calc_t;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_COUNT = 2'd3
  } cnt_act_e;

  // Up terminal also catches out-of-range values so a bad load recovers on the next count.
  function automatic logic is_terminal(input calc_t q, input logic ud, input calc_t modulus);
    logic term;
    if (ud == UP) term = (q >= (modulus - calc_t'(1)));
    else          term = (q == '0);
    return term;
  endfunction

  function automatic calc_t next_count(input calc_t q, input logic ud, input calc_t modulus);
    calc_t nxt;
    if (is_terminal(q, ud, modulus)) nxt = (ud == UP) ? '0 : (modulus - calc_t'(1));
    else                             nxt = (ud == UP) ? (q + calc_t'(1)) : (q - calc_t'(1));
    return nxt;
  endfunction

  // Edge action with clear > load > count > hold priority; pe_n is the active-low load strobe.
  function automatic cnt_act_e decode_action(input logic sr, input logic pe_n,
                                             input logic cep, input logic cet);
    cnt_act_e act;
    if (sr)              act = ACT_CLEAR;
    else if (!pe_n)      act = ACT_LOAD;
    else if (cep && cet) act = ACT_COUNT;
    else                 act = ACT_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/cnt_term_detect.sv
// Combinational terminal-state and cascade TC detection for one counter stage.
module cnt_term_detect
  import cnt_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             ud,
  input  logic             cet,
  output logic             term_c,
  output logic             tc_c
);

  always_comb begin
    term_c = is_terminal(calc_t'(q), ud, calc_t'(MODULUS));
    tc_c   = cet & term_c;
  end

endmodule

// File: rtl/cnt_updown_mod.sv
// Parametrised presettable up/down counter with sync clear, one-shot mode and cascade TC.
module cnt_updown_mod
  import cnt_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             SR,
  input  logic             PE,
  input  logic             CEP,
  input  logic             CET,
  input  logic             UD,
  input  logic             OS,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             DONE
);

  localparam longint unsigned MAX_MOD = 64'd1 << WIDTH;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("cnt_updown_mod: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > MAX_MOD) begin : g_bad_modulus
    $error("cnt_updown_mod: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
  end
  if (RST_VAL >= MODULUS) begin : g_bad_rst_val
    $error("cnt_updown_mod: RST_VAL=%0d not below MODULUS", RST_VAL);
  end

  logic             term_c;
  logic [WIDTH-1:0] step_c;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;
  cnt_act_e         act_c;

  cnt_term_detect #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_term (
    .q      (Q),
    .ud     (UD),
    .cet    (CET),
    .term_c (term_c),
    .tc_c   (TC)
  );

  assign step_c = WIDTH'(next_count(calc_t'(Q), UD, calc_t'(MODULUS)));

  // Next-state selection; one-shot at terminal freezes Q and latches DONE.
  always_comb begin
    q_nxt    = Q;
    done_nxt = DONE;
    act_c    = decode_action(SR, PE, CEP, CET);
    case (act_c)
      ACT_CLEAR: begin
        q_nxt    = '0;
        done_nxt = 1'b0;
      end
      ACT_LOAD: begin
        q_nxt    = D;
        done_nxt = 1'b0;
      end
      ACT_COUNT: begin
        if (OS == ONESHOT && term_c) done_nxt = 1'b1;
        else                         q_nxt    = step_c;
      end
      default: begin
        q_nxt    = Q;
        done_nxt = DONE;
      end
    endcase
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      Q    <= WIDTH'(RST_VAL);
      DONE <= 1'b0;
    end else begin
      Q    <= q_nxt;
      DONE <= done_nxt;
    end
  end

endmodule

// File: tb/tb_cnt_updown_mod.sv
// Directed bench for cnt_updown_mod: reset, wrap, one-shot, priority, out-of-range and cascade.
module tb_cnt_updown_mod;

  logic       clk = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  logic       mr, sr, pe, cep, cet, ud, os;
  logic [3:0] d, q;
  logic       tc, done;

  logic       c_mr, c_sr, c_pe, c_cep, c_cet0, c_ud, c_os;
  logic [3:0] c_d, q0, q1;
  logic       tc0, tc1, done0, done1;

  always #5 clk = ~clk;

  cnt_updown_mod #(.WIDTH(4), .MODULUS(10), .RST_VAL(3)) u_dut (
    .CP(clk), .MR(mr), .SR(sr), .PE(pe), .CEP(cep), .CET(cet), .UD(ud), .OS(os),
    .D(d), .Q(q), .TC(tc), .DONE(done)
  );

  cnt_updown_mod #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) u_stage0 (
    .CP(clk), .MR(c_mr), .SR(c_sr), .PE(c_pe), .CEP(c_cep), .CET(c_cet0), .UD(c_ud), .OS(c_os),
    .D(c_d), .Q(q0), .TC(tc0), .DONE(done0)
  );

  cnt_updown_mod #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) u_stage1 (
    .CP(clk), .MR(c_mr), .SR(c_sr), .PE(c_pe), .CEP(c_cep), .CET(tc0), .UD(c_ud), .OS(c_os),
    .D(c_d), .Q(q1), .TC(tc1), .DONE(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] cnt;
    mr = 1'b1; sr = 1'b0; pe = 1'b1; cep = 1'b0; cet = 1'b0; ud = 1'b1; os = 1'b0; d = 4'd0;
    c_mr = 1'b1; c_sr = 1'b0; c_pe = 1'b1; c_cep = 1'b0; c_cet0 = 1'b1; c_ud = 1'b1;
    c_os = 1'b0; c_d = 4'd0;
    #1;
    check("por_q", 32'(q), 32'd3);
    check("por_done", 32'(done), 32'd0);
    #1;
    mr = 1'b0; c_mr = 1'b0;

    // Reset between edges, then first count after release
    pe = 1'b0; d = 4'd8;
    step();
    check("load8", 32'(q), 32'd8);
    pe = 1'b1;
    mr = 1'b1;
    #1;
    check("mr_async_q", 32'(q), 32'd3);
    check("mr_async_done", 32'(done), 32'd0);
    #1;
    mr = 1'b0; cep = 1'b1; cet = 1'b1; ud = 1'b1;
    step();
    check("rel_first", 32'(q), 32'd4);

    // Decade wrap
    sr = 1'b1;
    step();
    sr = 1'b0;
    check("sr_clear", 32'(q), 32'd0);
    check("tc_q0_up", 32'(tc), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check("wrap_q", 32'(q), 32'(i % 10));
      check("wrap_tc", 32'(tc), 32'((i % 10) == 9));
      if ((i % 10) == 9) begin
        cet = 1'b0;
        #1;
        check("tc_cet0", 32'(tc), 32'd0);
        cet = 1'b1;
      end
    end
    sr = 1'b1;
    step();
    sr = 1'b0;
    ud = 1'b0;
    #1;
    check("tc_dn_q0", 32'(tc), 32'd1);
    step();
    check("dn_wrap", 32'(q), 32'd9);

    // One-shot down from 2
    os = 1'b1; ud = 1'b0; pe = 1'b0; d = 4'd2;
    step();
    pe = 1'b1;
    check("os_load", 32'(q), 32'd2);
    step();
    check("os_q1", 32'(q), 32'd1);
    check("os_d1", 32'(done), 32'd0);
    step();
    check("os_q0", 32'(q), 32'd0);
    check("os_d0", 32'(done), 32'd0);
    step();
    check("os_hold_q", 32'(q), 32'd0);
    check("os_done", 32'(done), 32'd1);
    step();
    check("os_hold_q2", 32'(q), 32'd0);
    check("os_sticky", 32'(done), 32'd1);
    cep = 1'b0; os = 1'b0; ud = 1'b1;
    step();
    check("os_mode_chg", 32'(done), 32'd1);
    pe = 1'b0; d = 4'd5;
    step();
    pe = 1'b1;
    check("os_reload_q", 32'(q), 32'd5);
    check("os_reload_done", 32'(done), 32'd0);

    // Priority SR > load > count
    sr = 1'b1; pe = 1'b0; d = 4'd7; cep = 1'b1; cet = 1'b1; ud = 1'b1;
    step();
    check("prio_sr", 32'(q), 32'd0);
    sr = 1'b0;
    step();
    check("prio_load", 32'(q), 32'd7);
    pe = 1'b1;

    // Out-of-range load
    cep = 1'b0; pe = 1'b0; d = 4'd13;
    step();
    pe = 1'b1;
    check("oor_load", 32'(q), 32'd13);
    check("oor_tc", 32'(tc), 32'd1);
    step();
    check("oor_hold", 32'(q), 32'd13);
    cep = 1'b1;
    step();
    check("oor_up", 32'(q), 32'd0);
    pe = 1'b0;
    step();
    pe = 1'b1; ud = 1'b0;
    #1;
    check("oor_tc_dn", 32'(tc), 32'd0);
    step();
    check("oor_dn", 32'(q), 32'd12);

    // Reset held across an edge while counting
    mr = 1'b1;
    step();
    check("mr_midcount", 32'(q), 32'd3);
    mr = 1'b0; cep = 1'b0;

    // Two-stage ripple cascade
    check("casc_q0_init", 32'(q0), 32'd0);
    check("casc_q1_init", 32'(q1), 32'd0);
    cnt = 8'd0;
    c_cep = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      cnt = cnt + 8'd1;
      check("casc_val", 32'({q1, q0}), 32'(cnt));
      check("casc_tc0", 32'(tc0), 32'(cnt[3:0] == 4'hF));
    end
    c_cep = 1'b0;
    check("casc_final", 32'({q1, q0}), 32'd44);
    check("casc_tc1", 32'(tc1), 32'd0);
    check("casc_done", 32'({done1, done0}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
